// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory access controller:
// state encoding, widths, defaults and the access-fault decode.
package dmem_access_ctrl_pkg;

    localparam int unsigned XLEN           = 64;
    localparam int unsigned ADDR_W_DEFAULT = 10;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } state_e;

    // An access faults if it is not doubleword aligned, lies above the
    // SRAM's byte range, or asks for a load and a store at once.
    function automatic logic accessFault(input logic [XLEN-1:0] addr,
                                         input logic            rd,
                                         input logic            wr,
                                         input int unsigned     addrW);
        logic misaligned;
        logic outOfRange;
        misaligned = (addr[2:0] != 3'b000);
        outOfRange = ((addr >> (addrW + 3)) != '0);
        return misaligned || outOfRange || (rd && wr);
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/ready bus between the MEM-stage access controller (master)
// and the data SRAM (slave).
interface dmem_access_ctrl_if #(
    parameter int unsigned AddrW = 10
) ();

    logic                                 mem_req;
    logic                                 mem_we;
    logic [AddrW-1:0]                     mem_addr;
    logic [dmem_access_ctrl_pkg::XLEN-1:0] mem_wdata;
    logic                                 mem_ready;
    logic [dmem_access_ctrl_pkg::XLEN-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_timeout_ctr.sv
// Cycle counter for an outstanding SRAM request; expire flags the last
// cycle the controller is allowed to wait for mem_ready.
module dmem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CntW = $clog2(TIMEOUT);

    logic [CntW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CntW'(1);
        end
    end

    assign expire = (count == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory access controller: turns EX/MEM load/store
// requests into SRAM req/ready transactions and stalls the pipeline meanwhile.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MemRead_in,
    input  logic               MemWrite_in,
    input  logic [XLEN-1:0]    addr_in,
    input  logic [XLEN-1:0]    wdata_in,
    output logic               stall,
    output logic [XLEN-1:0]    rdata_out,
    output logic               rdata_valid,
    output logic               err,
    dmem_access_ctrl_if.master memBus
);

    state_e state;
    logic   access;
    logic   fault;
    logic   ctrClr;
    logic   ctrEn;
    logic   ctrExpire;

    assign access = MemRead_in | MemWrite_in;
    assign fault  = accessFault(addr_in, MemRead_in, MemWrite_in, ADDR_W);
    assign ctrClr = (state == StIdle) && access && !fault;
    assign ctrEn  = (state == StReq);

    // DONE releases the pipeline so the finished instruction leaves EX/MEM.
    assign stall = ((state == StIdle) && access) || (state == StReq);

    dmem_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (ctrClr),
        .en    (ctrEn),
        .expire(ctrExpire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= StIdle;
            memBus.mem_req   <= 1'b0;
            memBus.mem_we    <= 1'b0;
            memBus.mem_addr  <= '0;
            memBus.mem_wdata <= '0;
            rdata_out        <= '0;
            rdata_valid      <= 1'b0;
            err              <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            err         <= 1'b0;
            case (state)
                StIdle: begin
                    if (access) begin
                        if (fault) begin
                            err   <= 1'b1;
                            state <= StDone;
                        end else begin
                            memBus.mem_req   <= 1'b1;
                            memBus.mem_we    <= MemWrite_in;
                            memBus.mem_addr  <= addr_in[ADDR_W+2:3];
                            memBus.mem_wdata <= wdata_in;
                            state            <= StReq;
                        end
                    end
                end
                StReq: begin
                    // A ready arriving in the final allowed cycle still wins.
                    if (memBus.mem_ready) begin
                        memBus.mem_req <= 1'b0;
                        if (!memBus.mem_we) begin
                            rdata_out   <= memBus.mem_rdata;
                            rdata_valid <= 1'b1;
                        end
                        state <= StDone;
                    end else if (ctrExpire) begin
                        memBus.mem_req <= 1'b0;
                        err            <= 1'b1;
                        rdata_out      <= '0;
                        state          <= StDone;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
